// File: rtl/cpu_bus_unit.sv
// cpu_bus_unit: serialises core fetch/load/store/push/pop requests onto the
// external memory bus. It owns the stack pointer, inserts wait states, honours
// mem_ready and aborts stalled accesses with an error pulse.
module cpu_bus_unit #(
  parameter int unsigned DATA_WIDTH  = 16,
  parameter int unsigned ADDR_WIDTH  = 16,
  parameter int unsigned WAIT_STATES = 0,
  parameter int unsigned TIMEOUT     = 64,
  parameter logic [ADDR_WIDTH-1:0] SP_RESET = 'h07FF
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  req,
  input  logic [2:0]            op,
  input  logic [ADDR_WIDTH-1:0] addr,
  input  logic [DATA_WIDTH-1:0] wdata,
  output logic                  ack,
  output logic                  done,
  output logic                  err,
  output logic [DATA_WIDTH-1:0] rdata,
  input  logic                  sp_load,
  input  logic [ADDR_WIDTH-1:0] sp_in,
  output logic [ADDR_WIDTH-1:0] sp,
  output logic [ADDR_WIDTH-1:0] address_bus,
  output logic [DATA_WIDTH-1:0] data_out,
  output logic                  data_oe,
  output logic                  r,
  output logic                  w,
  input  logic                  mem_ready,
  input  logic [DATA_WIDTH-1:0] read_bus
);

  localparam int unsigned WAIT_W = 4;
  localparam int unsigned TMO_W  = (TIMEOUT < 2) ? 1 : $clog2(TIMEOUT + 1);
  localparam bit          TMO_EN = (TIMEOUT != 0);
  localparam logic [TMO_W-1:0] TMO_LAST = TMO_W'((TIMEOUT == 0) ? 0 : TIMEOUT - 1);

  localparam logic [2:0] OP_FETCH = 3'd0;
  localparam logic [2:0] OP_LOAD  = 3'd1;
  localparam logic [2:0] OP_STORE = 3'd2;
  localparam logic [2:0] OP_PUSH  = 3'd3;
  localparam logic [2:0] OP_POP   = 3'd4;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACCESS = 2'd1,
    DONE   = 2'd2
  } state_t;

  state_t            state;
  logic [WAIT_W-1:0] wait_cnt;
  logic [TMO_W-1:0]  tmo_cnt;

  // A request is taken only in IDLE, and a same-cycle stack pointer load wins.
  assign ack = req & (state == IDLE) & ~sp_load;

  // Sequencer: request capture, strobe generation, wait/timeout counting and completion.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state       <= IDLE;
      sp          <= SP_RESET;
      address_bus <= '0;
      data_out    <= '0;
      rdata       <= '0;
      r           <= 1'b0;
      w           <= 1'b0;
      data_oe     <= 1'b0;
      done        <= 1'b0;
      err         <= 1'b0;
      wait_cnt    <= '0;
      tmo_cnt     <= '0;
    end else begin
      done <= 1'b0;
      err  <= 1'b0;
      unique case (state)
        IDLE: begin
          if (sp_load) begin
            sp <= sp_in;
          end else if (req) begin
            wait_cnt <= WAIT_W'(WAIT_STATES);
            tmo_cnt  <= '0;
            state    <= ACCESS;
            unique case (op)
              OP_FETCH, OP_LOAD: begin
                address_bus <= addr;
                r           <= 1'b1;
              end
              OP_STORE: begin
                address_bus <= addr;
                data_out    <= wdata;
                w           <= 1'b1;
                data_oe     <= 1'b1;
              end
              OP_PUSH: begin
                // Write at the current top, then move the pointer down.
                address_bus <= sp;
                sp          <= sp - ADDR_WIDTH'(1);
                data_out    <= wdata;
                w           <= 1'b1;
                data_oe     <= 1'b1;
              end
              OP_POP: begin
                // Move the pointer up, then read at the new top.
                address_bus <= sp + ADDR_WIDTH'(1);
                sp          <= sp + ADDR_WIDTH'(1);
                r           <= 1'b1;
              end
              default: begin
                // Reserved opcode: no bus cycle, report an error immediately.
                state <= DONE;
                done  <= 1'b1;
                err   <= 1'b1;
              end
            endcase
          end
        end

        ACCESS: begin
          if (wait_cnt != '0) begin
            wait_cnt <= wait_cnt - WAIT_W'(1);
          end else if (mem_ready) begin
            if (r) begin
              rdata <= read_bus;
            end
            state   <= DONE;
            done    <= 1'b1;
            r       <= 1'b0;
            w       <= 1'b0;
            data_oe <= 1'b0;
          end else if (TMO_EN) begin
            if (tmo_cnt == TMO_LAST) begin
              // Stalled too long: abort without touching rdata or sp.
              state   <= DONE;
              done    <= 1'b1;
              err     <= 1'b1;
              r       <= 1'b0;
              w       <= 1'b0;
              data_oe <= 1'b0;
            end else begin
              tmo_cnt <= tmo_cnt + TMO_W'(1);
            end
          end
        end

        DONE: begin
          state <= IDLE;
        end

        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_cpu_bus_unit.sv
// Testbench for cpu_bus_unit: two instances (no wait states / two wait states)
// driven by directed and random transactions, checked against a
// transaction-level model of the stack pointer, memory contents and timing.
module tb_cpu_bus_unit;

  localparam int WS0 = 0;
  localparam int TO0 = 4;
  localparam int WS1 = 2;
  localparam int TO1 = 5;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        reset;
  logic        req;
  logic        sp_load;
  logic        mem_ready;
  logic [2:0]  op;
  logic [15:0] addr;
  logic [15:0] wdata;
  logic [15:0] sp_in;
  logic [15:0] read_bus;
  int          sel;

  logic        req_a     [2];
  logic        sp_load_a [2];
  logic        ack_a     [2];
  logic        done_a    [2];
  logic        err_a     [2];
  logic        data_oe_a [2];
  logic        r_a       [2];
  logic        w_a       [2];
  logic [15:0] rdata_a   [2];
  logic [15:0] sp_a      [2];
  logic [15:0] abus_a    [2];
  logic [15:0] dout_a    [2];

  assign req_a[0]     = req & (sel == 0);
  assign req_a[1]     = req & (sel == 1);
  assign sp_load_a[0] = sp_load & (sel == 0);
  assign sp_load_a[1] = sp_load & (sel == 1);

  cpu_bus_unit #(
    .DATA_WIDTH(16), .ADDR_WIDTH(16), .WAIT_STATES(WS0), .TIMEOUT(TO0), .SP_RESET(16'h07FF)
  ) u_dut0 (
    .clk(clk), .reset(reset), .req(req_a[0]), .op(op), .addr(addr), .wdata(wdata),
    .ack(ack_a[0]), .done(done_a[0]), .err(err_a[0]), .rdata(rdata_a[0]),
    .sp_load(sp_load_a[0]), .sp_in(sp_in), .sp(sp_a[0]), .address_bus(abus_a[0]),
    .data_out(dout_a[0]), .data_oe(data_oe_a[0]), .r(r_a[0]), .w(w_a[0]),
    .mem_ready(mem_ready), .read_bus(read_bus)
  );

  cpu_bus_unit #(
    .DATA_WIDTH(16), .ADDR_WIDTH(16), .WAIT_STATES(WS1), .TIMEOUT(TO1), .SP_RESET(16'h07FF)
  ) u_dut1 (
    .clk(clk), .reset(reset), .req(req_a[1]), .op(op), .addr(addr), .wdata(wdata),
    .ack(ack_a[1]), .done(done_a[1]), .err(err_a[1]), .rdata(rdata_a[1]),
    .sp_load(sp_load_a[1]), .sp_in(sp_in), .sp(sp_a[1]), .address_bus(abus_a[1]),
    .data_out(dout_a[1]), .data_oe(data_oe_a[1]), .r(r_a[1]), .w(w_a[1]),
    .mem_ready(mem_ready), .read_bus(read_bus)
  );

  int checks   = 0;
  int failures = 0;

  // Reference model: stack pointer and last read data per instance, plus memory.
  logic [15:0] msp [2];
  logic [15:0] mrd [2];
  logic [15:0] mem [logic [16:0]];

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic model_reset();
    for (int i = 0; i < 2; i++) begin
      msp[i] = 16'h07FF;
      mrd[i] = 16'h0000;
    end
  endtask

  // One full transaction on instance d; nlow = mem_ready-low cycles after the wait states.
  task automatic run_txn(input int d, input logic [2:0] o, input logic [15:0] a,
                         input logic [15:0] wd, input int nlow, input logic [15:0] rv);
    int          ws, to, slen;
    logic        rd, wr, rsv, exp_err;
    logic [15:0] ea, nsp, val;
    logic [16:0] key;
    ws  = (d == 1) ? WS1 : WS0;
    to  = (d == 1) ? TO1 : TO0;
    rsv = (o > 3'd4);
    rd  = (o == 3'd0) || (o == 3'd1) || (o == 3'd4);
    wr  = (o == 3'd2) || (o == 3'd3);
    ea  = a;
    nsp = msp[d];
    if (o == 3'd3) begin
      ea  = msp[d];
      nsp = msp[d] - 16'd1;
    end
    if (o == 3'd4) begin
      nsp = msp[d] + 16'd1;
      ea  = nsp;
    end
    key = {1'(d), ea};
    val = (o == 3'd4 && mem.exists(key)) ? mem[key] : rv;
    if (rsv) begin
      slen = 0; exp_err = 1'b1;
    end else if (nlow >= to) begin
      slen = ws + to; exp_err = 1'b1;
    end else begin
      slen = ws + nlow + 1; exp_err = 1'b0;
    end

    @(posedge clk); #1;
    sel = d; req = 1'b1; op = o; addr = a; wdata = wd; sp_load = 1'b0;
    mem_ready = 1'($urandom); read_bus = 16'($urandom);
    #1 check_eq("ack", 32'(ack_a[d]), 32'd1);

    for (int k = 0; k <= slen; k++) begin
      @(posedge clk); #1;
      if (k < slen) begin
        check_eq("done_early", 32'(done_a[d]), 32'd0);
        check_eq("r_strobe", 32'(r_a[d]), 32'(rd));
        check_eq("w_strobe", 32'(w_a[d]), 32'(wr));
        check_eq("data_oe", 32'(data_oe_a[d]), 32'(wr));
        check_eq("address_bus", 32'(abus_a[d]), 32'(ea));
        if (wr) check_eq("data_out", 32'(dout_a[d]), 32'(wd));
        // Core-side inputs are scrambled; only mem_ready/read_bus matter now.
        req = 1'($urandom); sp_load = 1'($urandom); sp_in = 16'($urandom);
        op = 3'($urandom); addr = 16'($urandom); wdata = 16'($urandom);
        if (k < ws) begin
          mem_ready = 1'($urandom); read_bus = 16'($urandom);
        end else if (k - ws == nlow) begin
          mem_ready = 1'b1; read_bus = val;
        end else begin
          mem_ready = 1'b0; read_bus = 16'($urandom);
        end
        #1 check_eq("ack_busy", 32'(ack_a[d]), 32'd0);
      end else begin
        check_eq("done", 32'(done_a[d]), 32'd1);
        check_eq("err", 32'(err_a[d]), 32'(exp_err));
        check_eq("r_at_done", 32'(r_a[d]), 32'd0);
        check_eq("w_at_done", 32'(w_a[d]), 32'd0);
        check_eq("oe_at_done", 32'(data_oe_a[d]), 32'd0);
        if (!exp_err) begin
          if (rd) mrd[d] = val;
          if (wr) mem[key] = wd;
        end
        if (!rsv) msp[d] = nsp;
        check_eq("rdata", 32'(rdata_a[d]), 32'(mrd[d]));
        check_eq("sp", 32'(sp_a[d]), 32'(msp[d]));
        req = 1'b0; sp_load = 1'b0;
      end
    end
  endtask

  // Load the stack pointer while idle, with a competing request present.
  task automatic load_sp(input int d, input logic [15:0] v);
    @(posedge clk); #1;
    sel = d; sp_load = 1'b1; sp_in = v; req = 1'($urandom); op = 3'($urandom);
    #1 check_eq("ack_spload", 32'(ack_a[d]), 32'd0);
    msp[d] = v;
    @(posedge clk); #1;
    sp_load = 1'b0; req = 1'b0;
    check_eq("sp_loaded", 32'(sp_a[d]), 32'(v));
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    int d, o, nl, to;
    reset = 1'b0; req = 1'b0; sp_load = 1'b0; mem_ready = 1'b0; op = 3'd0;
    addr = '0; wdata = '0; sp_in = '0; read_bus = '0; sel = 0;
    model_reset();
    repeat (3) @(posedge clk);
    #1;
    for (int i = 0; i < 2; i++) begin
      check_eq("rst_sp", 32'(sp_a[i]), 32'h07FF);
      check_eq("rst_rdata", 32'(rdata_a[i]), 32'h0);
      check_eq("rst_abus", 32'(abus_a[i]), 32'h0);
      check_eq("rst_dout", 32'(dout_a[i]), 32'h0);
      check_eq("rst_r", 32'(r_a[i]), 32'd0);
      check_eq("rst_w", 32'(w_a[i]), 32'd0);
      check_eq("rst_oe", 32'(data_oe_a[i]), 32'd0);
      check_eq("rst_done", 32'(done_a[i]), 32'd0);
      check_eq("rst_err", 32'(err_a[i]), 32'd0);
    end
    @(negedge clk); reset = 1'b1;

    // LOAD with no wait states.
    run_txn(0, 3'd1, 16'h1234, 16'h0000, 0, 16'hBEEF);
    // PUSH then POP round trip through the stack.
    run_txn(0, 3'd3, 16'h0000, 16'hA5A5, 0, 16'h0000);
    run_txn(0, 3'd4, 16'h0000, 16'h0000, 0, 16'h0000);
    // Stack pointer wrap in both directions.
    load_sp(0, 16'h0000);
    run_txn(0, 3'd3, 16'h0000, 16'h3C3C, 0, 16'h0000);
    run_txn(0, 3'd4, 16'h0000, 16'h0000, 0, 16'h0000);
    // Two wait states plus three not-ready cycles.
    run_txn(1, 3'd1, 16'h4321, 16'h0000, 3, 16'h7777);
    // Timeout abort keeps rdata.
    run_txn(0, 3'd1, 16'h2222, 16'h0000, TO0, 16'hDEAD);
    run_txn(1, 3'd4, 16'h0000, 16'h0000, TO1 + 1, 16'hDEAD);
    // Reserved opcode.
    run_txn(0, 3'd6, 16'h5555, 16'h0000, 0, 16'h0000);

    // sp_load beats a same-cycle PUSH; the PUSH is taken the next cycle.
    @(posedge clk); #1;
    sel = 0; req = 1'b1; op = 3'd3; wdata = 16'h5A5A; sp_load = 1'b1; sp_in = 16'h0100;
    #1 check_eq("ack_prio", 32'(ack_a[0]), 32'd0);
    msp[0] = 16'h0100;
    run_txn(0, 3'd3, 16'h0000, 16'h5A5A, 0, 16'h0000);

    // Asynchronous reset in the middle of a STORE.
    @(posedge clk); #1;
    sel = 1; req = 1'b1; op = 3'd2; addr = 16'h00F0; wdata = 16'h1357; mem_ready = 1'b0;
    @(posedge clk); #1;
    req = 1'b0;
    check_eq("w_before_rst", 32'(w_a[1]), 32'd1);
    #2 reset = 1'b0;
    #1;
    check_eq("rst_async_w", 32'(w_a[1]), 32'd0);
    check_eq("rst_async_oe", 32'(data_oe_a[1]), 32'd0);
    check_eq("rst_async_sp", 32'(sp_a[1]), 32'h07FF);
    check_eq("rst_async_abus", 32'(abus_a[1]), 32'h0);
    model_reset();
    @(negedge clk); reset = 1'b1;
    mem_ready = 1'b1;
    repeat (4) begin
      @(posedge clk); #1;
      check_eq("no_done_after_rst", 32'(done_a[1]), 32'd0);
    end

    // Random traffic across both instances.
    for (int it = 0; it < 160; it++) begin
      d  = int'($urandom_range(0, 1));
      to = (d == 1) ? TO1 : TO0;
      if ($urandom_range(0, 9) == 0) begin
        load_sp(d, 16'($urandom));
      end
      o = int'($urandom_range(0, 9));
      o = (o < 8) ? (o % 5) : int'($urandom_range(5, 7));
      nl = ($urandom_range(0, 3) == 0) ? to + int'($urandom_range(0, 1))
                                       : int'($urandom_range(0, to - 1));
      run_txn(d, 3'(o), 16'($urandom), 16'($urandom), nl, 16'($urandom));
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
